// File: rtl/imem_reload_ctrl.sv
// Over-serial program reload sequencer: drains a full UART FIFO into memory and holds the CPU in reset meanwhile.
// Optional checksum on the last byte of each load is enabled by defining IMEM_RELOAD_CHECKSUM_EN.
module imem_reload_ctrl #(
  parameter int          DEPTH       = 512,
  parameter int          ADDR_W      = 9,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_full,
  output logic              fifo_full_ack,
  output logic [ADDR_W-1:0] fifo_raddr,
  output logic              fifo_addr_sel,
  input  logic [7:0]        fifo_rdata,
  output logic              mem_wen,
  output logic [31:0]       mem_wa,
  output logic [31:0]       mem_wd,
  output logic [2:0]        mem_funct3,
  output logic              busy,
  output logic              cpu_hold,
  output logic              checksum_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_ACK      = 3'd3;
  localparam logic [2:0] S_WAIT_CLR = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;

  localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              start_load;
  logic              err_q;
  logic              drain_wr;

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    vld_d      = 1'b0;
    start_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_full) start_load = 1'b1;
      end
      S_READ: begin
        // A falling fifo_full means the UART was reset under us: abandon the load.
        if (!fifo_full) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          vld_d = 1'b1;
          if (raddr_q == LAST_IDX) state_d = S_DRAIN;
          else                     raddr_d = raddr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!fifo_full) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = S_ACK;
        end
      end
      S_ACK: state_d = S_WAIT_CLR;
      S_WAIT_CLR: begin
        if (!fifo_full) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        // A rejected image keeps the CPU parked until the next load arrives.
        if (err_q) begin
          if (fifo_full) start_load = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (start_load) begin
      state_d = S_READ;
      raddr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HOLD;
      raddr_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Index of the byte arriving on fifo_rdata this cycle (one-cycle FIFO read latency).
  always_ff @(posedge clk) begin
    idx_q <= raddr_q;
  end

`ifdef IMEM_RELOAD_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic       err_d;

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (start_load) begin
      acc_d = '0;
      err_d = 1'b0;
    end else if (state_q == S_READ && vld_q) begin
      acc_d = acc_q + fifo_rdata;
    end else if (state_q == S_DRAIN && fifo_full && acc_q != fifo_rdata) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign drain_wr = 1'b0;
`else
  assign err_q    = 1'b0;
  assign drain_wr = 1'b1;
`endif

  assign mem_wen       = vld_q & (drain_wr | (state_q != S_DRAIN));
  assign mem_wa        = mem_wen ? (BASE_ADDR + 32'(idx_q)) : 32'h0;
  assign mem_wd        = mem_wen ? {24'h0, fifo_rdata} : 32'h0;
  assign mem_funct3    = 3'b000;
  assign fifo_raddr    = raddr_q;
  assign fifo_addr_sel = (state_q == S_READ) || (state_q == S_DRAIN);
  assign fifo_full_ack = (state_q == S_ACK);
  assign busy          = (state_q != S_IDLE);
  assign cpu_hold      = (state_q != S_IDLE);
  assign checksum_err  = err_q;

endmodule
